// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial-bit detector using a KMP transition table built at elaboration.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param #(
  parameter int             LEN     = 7,
  parameter logic [LEN-1:0] PATTERN = 7'b1111001,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  localparam int SW = $clog2(LEN);
  localparam int NS = 1 << SW;
  localparam logic [SW-1:0] LAST = SW'(LEN - 1);

  // One entry per {state, bit}; unreachable state codes are padded with 0.
  typedef logic [2*NS-1:0][SW-1:0] tbl_t;

  // Next state = longest pattern prefix that is a suffix of (matched prefix & x),
  // capped at LEN-1 so a full match lands on the pattern's longest border.
  function automatic tbl_t build_tbl();
    tbl_t t;
    int   k;
    int   p;
    logic ok;
    logic tb;
    t = '0;
    for (int s = 0; s < LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        k = 0;
        for (int c = ((s + 1 < LEN) ? s + 1 : LEN - 1); c > 0; c--) begin
          if (k == 0) begin
            ok = 1'b1;
            for (int i = 0; i < c; i++) begin
              p  = s + 1 - c + i;
              tb = (p == s) ? (b == 1) : PATTERN[LEN-1-p];
              if (tb != PATTERN[LEN-1-i]) ok = 1'b0;
            end
            if (ok) k = c;
          end
        end
        t[s*2+b] = SW'(k);
      end
    end
    return t;
  endfunction

  localparam tbl_t TBL = build_tbl();

  logic [SW-1:0] r_st;
  logic [SW-1:0] w_st_nxt;
  logic          w_z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= '0;
    else     r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    w_z      = 1'b0;
    if (r_st > LAST) begin
      w_st_nxt = '0;
    end else if (in_valid) begin
      w_z = (r_st == LAST) && (x == PATTERN[0]);
      if (w_z && !overlap) w_st_nxt = '0;
      else                 w_st_nxt = TBL[{r_st, x}];
    end
  end

  assign z = w_z;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (w_z && r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign match_count = r_cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random stream against an occurrence model.
module tb_seq_detector_param;
  localparam int             LEN   = 7;
  localparam logic [LEN-1:0] PAT   = 7'b1111001;
  localparam int             CNT_W = 2;
  localparam int             CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             x = 1'b0;
  logic             in_valid = 1'b0;
  logic             overlap = 1'b0;
  logic             z;
  logic [CNT_W-1:0] match_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: raw history of accepted bits; an occurrence counts if its LEN bits
  // all arrived after the last reset / last non-overlapping match.
  bit hist[$];
  int start_idx = 0;
  int m_cnt     = 0;
  int z_seen    = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.LEN(LEN), .PATTERN(PAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .z(z), .match_count(match_count)
  );

  function automatic int exp_cnt(input int k);
`ifdef SEQDET_COUNT_EN
    return (k > CMAX) ? CMAX : k;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic bx, input logic bv, input logic bov);
    logic m;
    int   n;
    x = bx; in_valid = bv; overlap = bov;
    m = 1'b0;
    if (bv) begin
      hist.push_back(bx);
      n = hist.size();
      if (n - start_idx >= LEN) begin
        m = 1'b1;
        for (int i = 0; i < LEN; i++)
          if (hist[n-LEN+i] != PAT[LEN-1-i]) m = 1'b0;
      end
      if (m) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!bov) start_idx = n;
      end
    end
    @(negedge clk);
    if (z === 1'b1) z_seen++;
    chk("z", {31'b0, z}, {31'b0, m});
    @(posedge clk); #1;
    chk("match_count", {{(32-CNT_W){1'b0}}, match_count}, exp_cnt(m_cnt));
  endtask

  task automatic feed(input logic [31:0] bits, input int nb, input logic ov);
    for (int i = nb - 1; i >= 0; i--) step(bits[i], 1'b1, ov);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_z", {31'b0, z}, 32'd0);
    chk("rst_cnt", {{(32-CNT_W){1'b0}}, match_count}, 32'd0);
    hist.delete();
    start_idx = 0;
    m_cnt     = 0;
    z_seen    = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic bv, bov, bx;
    int   fi;
    #1;
    do_reset();

    // non-overlapping: only the first occurrence
    feed(32'b1111001111001, 13, 1'b0);
    chk("nonovl_hits", z_seen, 32'd1);
    chk("nonovl_cnt", {{(32-CNT_W){1'b0}}, match_count}, exp_cnt(1));

    // overlapping: border "1" reused
    do_reset();
    feed(32'b1111001111001, 13, 1'b1);
    chk("ovl_hits", z_seen, 32'd2);
    chk("ovl_cnt", {{(32-CNT_W){1'b0}}, match_count}, exp_cnt(2));

    // mismatch recovery
    do_reset();
    feed(32'b11111001, 8, 1'b1);
    chk("rec1_hits", z_seen, 32'd1);
    do_reset();
    feed(32'b11101111001, 11, 1'b1);
    chk("rec2_hits", z_seen, 32'd1);

    // stall with toggling x
    do_reset();
    feed(32'b1111, 4, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    feed(32'b001, 3, 1'b1);
    chk("stall_hits", z_seen, 32'd1);

    // reset mid-pattern discards the partial match
    do_reset();
    feed(32'b11110, 5, 1'b1);
    do_reset();
    feed(32'b01, 2, 1'b1);
    chk("rstmid_hits", z_seen, 32'd0);
    feed(32'b1111001, 7, 1'b1);
    chk("rstmid_after", z_seen, 32'd1);

    // saturation: five back-to-back overlapping matches
    do_reset();
    feed(32'b1111001, 7, 1'b1);
    for (int r = 0; r < 4; r++) feed(32'b111001, 6, 1'b1);
    chk("sat_hits", z_seen, 32'd5);
    chk("sat_cnt", {{(32-CNT_W){1'b0}}, match_count}, exp_cnt(5));

    // random stream biased toward pattern bits
    do_reset();
    fi = 0;
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        fi = 0;
      end
      bv  = ($urandom_range(0, 9) != 0);
      bov = ($urandom_range(0, 7) != 0);
      bx  = ($urandom_range(0, 3) != 0) ? PAT[LEN-1-fi] : 1'($urandom_range(0, 1));
      if (bv) fi = (fi + 1) % LEN;
      step(bx, bv, bov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-bit sequence detector, the generalised successor to the team's fixed-pattern detectors. Pattern, pattern length and overlap mode are configurable. Mismatch recovery uses the pattern's longest-border (KMP) transitions, so partial matches are never lost. It sits on a single-bit serial input path and flags each complete pattern occurrence in the cycle its last bit arrives, with an optional saturating match counter.

## Interface
- LEN, default 7: pattern length in bits. Legal range 2..32.
- PATTERN, default 7'b1111001: pattern to detect. PATTERN[LEN-1] is the first bit received; PATTERN[0] is the last.
- CNT_W, default 8: width of match_count.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit.
- in_valid  input  1  x is sampled only when in_valid=1.
- overlap  input  1  mode select. 1 = overlapping detection; 0 = non-overlapping. Sampled every valid cycle.
- z  output  1  Mealy match flag, combinational from state, x, in_valid.
- match_count  output  CNT_W  number of matches since reset.

## Operation
- State register `st` in 0..LEN-1 holds the number of pattern bits currently matched. Width is clog2(LEN).
- Match condition: `z = in_valid && (st == LEN-1) && (x == PATTERN[0])`.
- Next state on a valid cycle, with `b = PATTERN[LEN-1-st]` as the expected bit:
  - x == b and st < LEN-1: st+1.
  - Match with overlap=1: st = F(LEN). F(k) is the length of the longest proper prefix of the pattern that is also a suffix of its first k bits.
  - Match with overlap=0: st = 0.
  - x != b: st = length of the longest pattern prefix that is a suffix of (matched prefix & x). This is the KMP automaton.
- The transition table is computed at elaboration by a constant function from PATTERN and LEN. There is no runtime pattern load.
- in_valid=0: st holds, z=0, match_count holds.
- Flipping `overlap` mid-stream affects only the next match transition.
- States are decoded exhaustively. Any state value >= LEN goes to 0 on the next clock, regardless of in_valid.

## Timing
- Reset (asynchronous, immediate): st=0, z=0, match_count=0. After rst deasserts, the first valid bit is sampled on the next rising edge.
- z latency: 0 cycles. z is high in the same cycle the final pattern bit is presented with in_valid=1, and is valid before the capturing edge.
- match_count increments on the same edge that captures the matching bit. It is visible the cycle after z.
- Reset asserted mid-match discards the partial match. A pattern straddling the reset is not detected.
- Back-to-back matches in overlap mode are possible every (LEN − F(LEN)) valid cycles. In non-overlap mode they are possible every LEN valid cycles.

## Configuration
- SEQDET_COUNT_EN defined: match_count is a CNT_W-bit counter. It increments on each match and saturates at 2^CNT_W−1, with no wrap.
- SEQDET_COUNT_EN undefined: the counter is not built and match_count is tied to 0. The port list is unchanged. z behaviour is identical in both builds.

## Test plan
All scenarios use the defaults (LEN=7, PATTERN=1111001) with in_valid=1 unless stated.
- Non-overlap: stream 1111001111001, overlap=0 → z=1 only at bit 7. The trailing 111001 gives no match. match_count=1.
- Overlap: same stream, overlap=1 → z=1 at bits 7 and 13 (border "1" reused). match_count=2.
- Mismatch recovery: stream 11111001 → z=1 at bit 8 only, since the extra 1 keeps st=4. Stream 1110 1111001 → z=1 at bit 11.
- Stall: 1111 then in_valid=0 for 3 cycles with x toggling, then 001 → z stays 0 during the stall and z=1 on the final 1.
- Reset mid-pattern: 11110 then rst pulse, then 01 → no match. A full 1111001 afterwards → z=1 at its 7th bit. match_count is 0 after reset.
- Saturation (macro on, CNT_W=2): 5 matches in overlap mode → match_count reads 1,2,3,3,3. Macro off → match_count=0 throughout.
